grf_wb_arbiter: RTL and testbench

Write-port arbiter and scheduler for the 32×32 general register file. It shares the single GRF write port between two requesters:
- the in-order pipeline writeback (port A), which always has priority;
- a long-latency result source such as the multiply/divide unit (port B), buffered in a small FIFO.

It also keeps a pending-write scoreboard for the hazard unit and kills queued writes made stale by a newer pipeline write.

---
 rtl/grf_pkg.sv | 32 +++
 rtl/wb_req_fifo.sv | 75 +++++++
 rtl/grf_wb_arbiter.sv | 117 +++++++++++
 tb/tb_grf_wb_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/grf_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | grf_pkg                                                          |
// | Shared register-file write types and constants.                  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package grf_pkg;

  localparam int REG_AW   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] pc;
  } wb_req_t;

  typedef struct packed {
    logic    live;
    wb_req_t req;
  } fifo_ent_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_AW-1:0] r);
    logic [NUM_REGS-1:0] v;
    v    = '0;
    v[r] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_req_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | wb_req_fifo                                                      |
// | In-order write-request queue with per-entry live bit and         |
// | kill-by-address.                                                 |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module wb_req_fifo
  import grf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  wb_req_t                 push_req,
  input  logic                    pop,
  input  logic                    kill,
  input  logic [REG_AW-1:0]       kill_addr,
  output fifo_ent_t               head,
  output logic                    empty,
  output logic                    full,
  output logic [DEPTH-1:0]        ent_live,
  output logic [DEPTH*REG_AW-1:0] ent_addr
);

  localparam int AW = $clog2(DEPTH);

  fifo_ent_t   r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;

  always_comb begin
    empty = (r_wr_ptr == r_rd_ptr);
    full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
            (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  end

  assign head = r_mem[r_rd_ptr[AW-1:0]];

  generate
    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
      assign ent_live[g]                   = r_mem[g].live;
      assign ent_addr[g*REG_AW +: REG_AW]  = r_mem[g].req.addr;
    end
  endgenerate

  // Popped slots drop their live bit so the scoreboard only sees queued work;
  // the push is written last so a same-cycle kill never hits the younger entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill && r_mem[i].live && (r_mem[i].req.addr == kill_addr)) begin
          r_mem[i].live <= 1'b0;
        end
      end
      if (pop && !empty) begin
        r_mem[r_rd_ptr[AW-1:0]].live <= 1'b0;
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (push && !full) begin
        r_mem[r_wr_ptr[AW-1:0]] <= '{live: 1'b1, req: push_req};
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/grf_wb_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | grf_wb_arbiter                                                   |
// | GRF write-port arbiter: pipeline writeback over buffered port B, |
// | pending-write scoreboard. Optional GRF_ARB_B_BYPASS_EN lets B    |
// | write straight through when idle.                                |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module grf_wb_arbiter
  import grf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                a_we,
  input  logic [REG_AW-1:0]   a_addr,
  input  logic [DATA_W-1:0]   a_data,
  input  logic [DATA_W-1:0]   a_pc,
  input  logic                b_valid,
  output logic                b_ready,
  input  logic [REG_AW-1:0]   b_addr,
  input  logic [DATA_W-1:0]   b_data,
  input  logic [DATA_W-1:0]   b_pc,
  output logic                grf_we,
  output logic [REG_AW-1:0]   grf_addr,
  output logic [DATA_W-1:0]   grf_data,
  output logic [DATA_W-1:0]   grf_pc,
  output logic [NUM_REGS-1:0] pending_mask
);

  logic                    w_a_valid;
  logic                    w_b_take;
  logic                    w_bypass;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_empty;
  logic                    w_full;
  fifo_ent_t               w_head;
  wb_req_t                 w_b_req;
  logic [DEPTH-1:0]        w_ent_live;
  logic [DEPTH*REG_AW-1:0] w_ent_addr;
  logic [NUM_REGS-1:0]     w_mask;

  assign w_a_valid = a_we && (a_addr != '0);
  assign b_ready   = !reset && !w_full;
  assign w_b_take  = b_valid && b_ready && (b_addr != '0);
  assign w_b_req   = '{addr: b_addr, data: b_data, pc: b_pc};

`ifdef GRF_ARB_B_BYPASS_EN
  assign w_bypass  = w_b_take && w_empty && !w_a_valid;
`else
  assign w_bypass  = 1'b0;
`endif

  assign w_push = w_b_take && !w_bypass;
  assign w_pop  = !w_a_valid && !w_empty;

  wb_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .push_req  (w_b_req),
    .pop       (w_pop),
    .kill      (w_a_valid),
    .kill_addr (a_addr),
    .head      (w_head),
    .empty     (w_empty),
    .full      (w_full),
    .ent_live  (w_ent_live),
    .ent_addr  (w_ent_addr)
  );

  // A killed head still costs its pop cycle, leaving the port idle.
  always_comb begin
    grf_we   = 1'b0;
    grf_addr = '0;
    grf_data = '0;
    grf_pc   = '0;
    if (!reset) begin
      if (w_a_valid) begin
        grf_we   = 1'b1;
        grf_addr = a_addr;
        grf_data = a_data;
        grf_pc   = a_pc;
      end else if (!w_empty) begin
        if (w_head.live) begin
          grf_we   = 1'b1;
          grf_addr = w_head.req.addr;
          grf_data = w_head.req.data;
          grf_pc   = w_head.req.pc;
        end
      end else if (w_bypass) begin
        grf_we   = 1'b1;
        grf_addr = b_addr;
        grf_data = b_data;
        grf_pc   = b_pc;
      end
    end
  end

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_ent_live[i]) begin
        w_mask = w_mask | reg_onehot(w_ent_addr[i*REG_AW +: REG_AW]);
      end
    end
    w_mask[0] = 1'b0;
  end

  assign pending_mask = w_mask;

endmodule
`default_nettype wire

// File: tb/tb_grf_wb_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_grf_wb_arbiter                                                |
// | Directed and random checks against a queue-based reference.      |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_grf_wb_arbiter;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_we;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic [31:0] a_pc;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic [31:0] b_pc;
  logic        grf_we;
  logic [4:0]  grf_addr;
  logic [31:0] grf_data;
  logic [31:0] grf_pc;
  logic [31:0] pending_mask;

  grf_wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .a_we         (a_we),
    .a_addr       (a_addr),
    .a_data       (a_data),
    .a_pc         (a_pc),
    .b_valid      (b_valid),
    .b_ready      (b_ready),
    .b_addr       (b_addr),
    .b_data       (b_data),
    .b_pc         (b_pc),
    .grf_we       (grf_we),
    .grf_addr     (grf_addr),
    .grf_data     (grf_data),
    .grf_pc       (grf_pc),
    .pending_mask (pending_mask)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit last_acc;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
    bit          live;
  } ment_t;

  ment_t q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, compare against the queue model, advance the model.
  task automatic cyc(input bit rst, input bit we, input logic [4:0] aa,
                     input logic [31:0] ad, input logic [31:0] ap,
                     input bit bv, input logic [4:0] ba,
                     input logic [31:0] bd, input logic [31:0] bp);
    bit          av, exp_rdy, exp_we, bypass;
    logic [4:0]  ea;
    logic [31:0] ed, ep, em;
    reset = rst; a_we = we; a_addr = aa; a_data = ad; a_pc = ap;
    b_valid = bv; b_addr = ba; b_data = bd; b_pc = bp;
    #3;
    av      = we && (aa != 0);
    exp_rdy = !rst && (q.size() < DEPTH);
    em = '0;
    foreach (q[i]) if (q[i].live) em[q[i].addr] = 1'b1;
    em[0] = 1'b0;
    bypass = 0; exp_we = 0; ea = '0; ed = '0; ep = '0;
    if (!rst) begin
      if (av) begin
        exp_we = 1; ea = aa; ed = ad; ep = ap;
      end else if (q.size() > 0) begin
        if (q[0].live) begin
          exp_we = 1; ea = q[0].addr; ed = q[0].data; ep = q[0].pc;
        end
      end
`ifdef GRF_ARB_B_BYPASS_EN
      else if (bv && ba != 0) begin
        bypass = 1; exp_we = 1; ea = ba; ed = bd; ep = bp;
      end
`endif
    end
    check("b_ready", {31'b0, b_ready}, {31'b0, exp_rdy});
    check("grf_we", {31'b0, grf_we}, {31'b0, exp_we});
    if (exp_we) begin
      check("grf_addr", {27'b0, grf_addr}, {27'b0, ea});
      check("grf_data", grf_data, ed);
      check("grf_pc", grf_pc, ep);
    end
    check("pending_mask", pending_mask, em);
    last_acc = bv && exp_rdy;
    @(posedge clk);
    if (rst) begin
      q.delete();
    end else begin
      if (av) begin
        foreach (q[i]) if (q[i].addr == aa) q[i].live = 0;
      end else if (q.size() > 0) begin
        void'(q.pop_front());
      end
      if (bv && exp_rdy && ba != 0 && !bypass) q.push_back('{ba, bd, bp, 1'b1});
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  int nb;

  initial begin
    reset = 1; a_we = 0; a_addr = 0; a_data = 0; a_pc = 0;
    b_valid = 0; b_addr = 0; b_data = 0; b_pc = 0;
    @(posedge clk); @(posedge clk); #1;
    reset = 0;
    #3;
    check("rst_b_ready", {31'b0, b_ready}, 32'd1);
    check("rst_grf_we", {31'b0, grf_we}, 32'd0);
    check("rst_grf_addr", {27'b0, grf_addr}, 32'd0);
    check("rst_grf_data", grf_data, 32'd0);
    check("rst_grf_pc", grf_pc, 32'd0);
    check("rst_mask", pending_mask, 32'd0);
    @(posedge clk); #1;

    // A only, then B only
    cyc(0, 1, 5, 32'h1234, 32'h3000, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 3, 32'hAA, 32'h4000);
    idle(2);

    // Contention: A busy six cycles while B offers 8..12
    nb = 8;
    for (int i = 0; i < 6; i++) begin
      cyc(0, 1, 5'(20 + i), 32'h100 + i, 32'h5000 + 4 * i, 1, 5'(nb), 32'hB00 + nb, 32'h6000 + nb);
      if (last_acc) nb++;
    end
    check("contention_accepted", nb - 8, 32'd4);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0, 0, 0, nb <= 12, 5'(nb), 32'hB00 + nb, 32'h6000 + nb);
      if (last_acc) nb++;
    end
    check("contention_all_pushed", nb, 32'd13);

    // WAW kill
    cyc(0, 1, 1, 32'h1, 32'h7000, 1, 7, 32'h11, 32'h7100);
    cyc(0, 1, 7, 32'h22, 32'h7004, 0, 0, 0, 0);
    idle(2);

    // $0 on both ports
    cyc(0, 0, 0, 0, 0, 1, 0, 32'hFF, 32'h8000);
    idle(1);
    cyc(0, 1, 2, 32'h2, 32'h8100, 1, 4, 32'h44, 32'h8200);
    cyc(0, 1, 0, 32'h99, 32'h8300, 1, 6, 32'h66, 32'h8400);
    idle(2);

    // Reset with three entries queued
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 0, 1, 5'(13 + i), 32'hC0 + i, 32'h9000 + i);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(5);

    // Random traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
          $urandom, $urandom, $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)),
          $urandom, $urandom);
    end
    idle(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
